// File: rtl/cpu_alu_seq_pkg.sv
// Shared types and constants for the sequenced 6502-style ALU front end.
// Optional build macro CPU_ALU_SEQ_PLOAD_EN (see cpu_alu_seq) adds a status preload port.
package cpu_alu_seq_pkg;

   localparam int unsigned NUM_B = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_e;

   typedef enum logic [3:0] {
      OP_ORA = 4'd0,
      OP_AND = 4'd1,
      OP_EOR = 4'd2,
      OP_ADC = 4'd3,
      OP_SBC = 4'd4,
      OP_CMP = 4'd5,
      OP_BIT = 4'd6,
      OP_ASL = 4'd7,
      OP_LSR = 4'd8,
      OP_ROL = 4'd9,
      OP_ROR = 4'd10,
      OP_INC = 4'd11,
      OP_DEC = 4'd12
   } op_e;

   typedef enum logic [1:0] {
      ALU_OR  = 2'd0,
      ALU_AND = 2'd1,
      ALU_XOR = 2'd2,
      ALU_ADC = 2'd3
   } alu_funct_e;

   typedef enum logic [1:0] {
      OPB_SHL = 2'd0,
      OPB_SHR = 2'd1,
      OPB_INC = 2'd2,
      OPB_DEC = 2'd3
   } opb_funct_e;

   localparam int P_C = 0;
   localparam int P_Z = 1;
   localparam int P_I = 2;
   localparam int P_D = 3;
   localparam int P_B = 4;
   localparam int P_U = 5;
   localparam int P_V = 6;
   localparam int P_N = 7;

   localparam logic [NUM_B-1:0] P_RESET  = 8'h24;
   localparam logic [NUM_B-1:0] P_U_MASK = 8'h20;

   typedef struct packed {
      logic n;
      logic v;
      logic z;
      logic c;
   } flags_t;

   typedef struct packed {
      alu_funct_e       funct;
      opb_funct_e       opb_funct;
      logic             opb_en;
      logic             cin;
      logic [NUM_B-1:0] opa;
      logic [NUM_B-1:0] opb;
   } alu_drv_t;

   localparam alu_drv_t ALU_DRV_IDLE = '{
      funct:     ALU_OR,
      opb_funct: OPB_SHL,
      opb_en:    1'b0,
      cin:       1'b0,
      opa:       8'h00,
      opb:       8'h00
   };

endpackage

// File: rtl/alu_if.sv
// Connection to the shared ALU: the sequencer is master, the ALU answers combinationally.
interface alu_if
   import cpu_alu_seq_pkg::*;
#(
   parameter int NumB = 8
);
   alu_funct_e      ALU_Funct;
   opb_funct_e      ALU_OpB_Funct;
   logic            ALU_OpB_FunctEn;
   logic            Cin;
   logic [NumB-1:0] ALU_Rslt;
   logic            NFlg;
   logic            ZFlg;
   logic            VFlg;
   logic            CFlg;

   modport mst (
      output ALU_Funct, ALU_OpB_Funct, ALU_OpB_FunctEn, Cin,
      input  ALU_Rslt, NFlg, ZFlg, VFlg, CFlg
   );

   modport slv (
      input  ALU_Funct, ALU_OpB_Funct, ALU_OpB_FunctEn, Cin,
      output ALU_Rslt, NFlg, ZFlg, VFlg, CFlg
   );
endinterface

// File: rtl/cpu_alu_seq_pupd.sv
// Processor status register P with per-operation flag update masks.
// With CPU_ALU_SEQ_PLOAD_EN defined, an external preload path is added.
module cpu_alu_seq_pupd
   import cpu_alu_seq_pkg::*;
#(
   parameter int NumB = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            upd_en_i,
   input  logic [3:0]      op_i,
   input  flags_t          flg_i,
   input  logic [1:0]      bit_nv_i,
`ifdef CPU_ALU_SEQ_PLOAD_EN
   input  logic            ld_en_i,
   input  logic [NumB-1:0] ld_val_i,
`endif
   output logic [NumB-1:0] status_o
);

   logic [NumB-1:0] status_q;
   logic [NumB-1:0] status_d;
   flags_t          mask_s;
   flags_t          new_s;
   logic            ld_en_s;
   logic [NumB-1:0] ld_val_s;

   function automatic flags_t flag_mask(input logic [3:0] op);
      flags_t m;
      case (op_e'(op))
         OP_ORA, OP_AND, OP_EOR,
         OP_INC, OP_DEC:          m = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b0};
         OP_ADC, OP_SBC:          m = '{n: 1'b1, v: 1'b1, z: 1'b1, c: 1'b1};
         OP_CMP, OP_ASL, OP_LSR,
         OP_ROL, OP_ROR:          m = '{n: 1'b1, v: 1'b0, z: 1'b1, c: 1'b1};
         OP_BIT:                  m = '{n: 1'b1, v: 1'b1, z: 1'b1, c: 1'b0};
         default:                 m = '{n: 1'b0, v: 1'b0, z: 1'b0, c: 1'b0};
      endcase
      return m;
   endfunction

`ifdef CPU_ALU_SEQ_PLOAD_EN
   assign ld_en_s  = ld_en_i;
   assign ld_val_s = ld_val_i;
`else
   assign ld_en_s  = 1'b0;
   assign ld_val_s = '0;
`endif

   // Next P: masked flag merge on write-back, else preload, else hold; bit 5 always set.
   always_comb begin
      mask_s   = flag_mask(op_i);
      new_s    = flg_i;
      // BIT takes N and V straight from the memory operand, not from the ALU.
      new_s.n  = (op_i == OP_BIT) ? bit_nv_i[1] : flg_i.n;
      new_s.v  = (op_i == OP_BIT) ? bit_nv_i[0] : flg_i.v;
      status_d = status_q;
      if (upd_en_i) begin
         status_d[P_N] = mask_s.n ? new_s.n : status_q[P_N];
         status_d[P_V] = mask_s.v ? new_s.v : status_q[P_V];
         status_d[P_Z] = mask_s.z ? new_s.z : status_q[P_Z];
         status_d[P_C] = mask_s.c ? new_s.c : status_q[P_C];
      end else if (ld_en_s) begin
         status_d = ld_val_s | P_U_MASK;
      end else begin
         status_d = status_q;
      end
      status_d[P_U] = 1'b1;
   end

   // Status register storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= P_RESET;
      end else begin
         status_q <= status_d;
      end
   end

   assign status_o = status_q;

endmodule

// File: rtl/cpu_alu_seq.sv
// Three-state (IDLE/EXEC/WB) sequencer that maps 6502-style ALU ops onto a shared ALU.
// Optional macro CPU_ALU_SEQ_PLOAD_EN adds p_ld_en/p_ld_val for loading the status register.
module cpu_alu_seq
   import cpu_alu_seq_pkg::*;
#(
   parameter int NumB = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_if.mst              alu_if,
   output logic [NumB-1:0] alu_opa,
   output logic [NumB-1:0] alu_opb,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_op,
   input  logic [NumB-1:0] req_a,
   input  logic [NumB-1:0] req_b,
   output logic            rsp_valid,
   output logic [NumB-1:0] rsp_result,
   output logic [NumB-1:0] status_p
`ifdef CPU_ALU_SEQ_PLOAD_EN
   ,
   input  logic            p_ld_en,
   input  logic [NumB-1:0] p_ld_val
`endif
);

   state_e          state_q;
   logic            ready_q;
   logic [3:0]      op_q;
   logic [NumB-1:0] b_q;
   alu_drv_t        drv_q;
   logic [NumB-1:0] rslt_q;
   flags_t          flg_q;
   logic            rsp_valid_q;
   logic [NumB-1:0] rsp_result_q;
   logic            accept_s;
   logic            upd_en_s;

   // Operand and function selection for one operation; shifts/INC/DEC run through OpB with OpA=0.
   function automatic alu_drv_t decode_op(input logic [3:0] op, input logic [NumB-1:0] a,
                                          input logic [NumB-1:0] b, input logic c);
      alu_drv_t d;
      d = '{funct: ALU_OR, opb_funct: OPB_SHL, opb_en: 1'b0, cin: 1'b0, opa: a, opb: b};
      case (op_e'(op))
         OP_ORA: d.funct = ALU_OR;
         OP_AND, OP_BIT: d.funct = ALU_AND;
         OP_EOR: d.funct = ALU_XOR;
         OP_ADC: begin
            d.funct = ALU_ADC;
            d.cin   = c;
         end
         OP_SBC: begin
            d.funct = ALU_ADC;
            d.opb   = ~b;
            d.cin   = c;
         end
         OP_CMP: begin
            d.funct = ALU_ADC;
            d.opb   = ~b;
            d.cin   = 1'b1;
         end
         OP_ASL, OP_ROL: begin
            d.opa       = '0;
            d.opb_en    = 1'b1;
            d.opb_funct = OPB_SHL;
            d.cin       = (op == OP_ROL) ? c : 1'b0;
         end
         OP_LSR, OP_ROR: begin
            d.opa       = '0;
            d.opb_en    = 1'b1;
            d.opb_funct = OPB_SHR;
            d.cin       = (op == OP_ROR) ? c : 1'b0;
         end
         OP_INC: begin
            d.opa       = '0;
            d.opb_en    = 1'b1;
            d.opb_funct = OPB_INC;
         end
         OP_DEC: begin
            d.opa       = '0;
            d.opb_en    = 1'b1;
            d.opb_funct = OPB_DEC;
         end
         // Reserved codes pass req_b through as 0 | b.
         default: d.opa = '0;
      endcase
      return d;
   endfunction

`ifdef CPU_ALU_SEQ_PLOAD_EN
   assign req_ready = ready_q & ~p_ld_en;
`else
   assign req_ready = ready_q;
`endif

   assign accept_s = req_valid & req_ready;
   assign upd_en_s = (state_q == ST_WB);

   // Sequencer: capture on accept, drive the ALU in EXEC, write back in WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ready_q      <= 1'b1;
         op_q         <= 4'd0;
         b_q          <= '0;
         drv_q        <= ALU_DRV_IDLE;
         rslt_q       <= '0;
         flg_q        <= '{n: 1'b0, v: 1'b0, z: 1'b0, c: 1'b0};
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               rsp_valid_q <= 1'b0;
               if (accept_s) begin
                  state_q <= ST_EXEC;
                  ready_q <= 1'b0;
                  op_q    <= req_op;
                  b_q     <= req_b;
                  drv_q   <= decode_op(req_op, req_a, req_b, status_p[P_C]);
               end else begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
               end
            end
            ST_EXEC: begin
               state_q     <= ST_WB;
               rsp_valid_q <= 1'b0;
               drv_q       <= ALU_DRV_IDLE;
               rslt_q      <= alu_if.ALU_Rslt;
               flg_q       <= '{n: alu_if.NFlg, v: alu_if.VFlg, z: alu_if.ZFlg, c: alu_if.CFlg};
            end
            ST_WB: begin
               state_q      <= ST_IDLE;
               ready_q      <= 1'b1;
               rsp_valid_q  <= 1'b1;
               rsp_result_q <= rslt_q;
            end
            default: begin
               state_q     <= ST_IDLE;
               ready_q     <= 1'b1;
               rsp_valid_q <= 1'b0;
               drv_q       <= ALU_DRV_IDLE;
            end
         endcase
      end
   end

   assign alu_if.ALU_Funct       = drv_q.funct;
   assign alu_if.ALU_OpB_Funct   = drv_q.opb_funct;
   assign alu_if.ALU_OpB_FunctEn = drv_q.opb_en;
   assign alu_if.Cin             = drv_q.cin;
   assign alu_opa                = drv_q.opa;
   assign alu_opb                = drv_q.opb;
   assign rsp_valid              = rsp_valid_q;
   assign rsp_result             = rsp_result_q;

   cpu_alu_seq_pupd #(
      .NumB     (NumB)
   ) u_pupd (
      .clk      (clk),
      .rst_n    (rst_n),
      .upd_en_i (upd_en_s),
      .op_i     (op_q),
      .flg_i    (flg_q),
      .bit_nv_i (b_q[7:6]),
`ifdef CPU_ALU_SEQ_PLOAD_EN
      .ld_en_i  (p_ld_en & (state_q == ST_IDLE)),
      .ld_val_i (p_ld_val),
`endif
      .status_o (status_p)
   );

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Directed, table-driven bench for cpu_alu_seq with a behavioural ALU on the slave side.
module tb_cpu_alu_seq;
   import cpu_alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] alu_opa, alu_opb;
   logic       req_valid, req_ready;
   logic [3:0] req_op;
   logic [7:0] req_a, req_b;
   logic       rsp_valid;
   logic [7:0] rsp_result, status_p;
`ifdef CPU_ALU_SEQ_PLOAD_EN
   logic       p_ld_en;
   logic [7:0] p_ld_val;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_if #(.NumB(8)) aif ();

   // Behavioural ALU: OpB pre-function, then OpA <funct> OpB'.
   logic [7:0] m_b2, m_r;
   logic [8:0] m_sum;
   logic       m_sc, m_c, m_v;
   always_comb begin
      m_b2  = alu_opb;
      m_sc  = 1'b0;
      m_sum = 9'd0;
      m_r   = 8'h00;
      m_c   = 1'b0;
      m_v   = 1'b0;
      if (aif.ALU_OpB_FunctEn) begin
         case (aif.ALU_OpB_Funct)
            OPB_SHL: begin m_b2 = {alu_opb[6:0], aif.Cin}; m_sc = alu_opb[7]; end
            OPB_SHR: begin m_b2 = {aif.Cin, alu_opb[7:1]}; m_sc = alu_opb[0]; end
            OPB_INC: m_b2 = alu_opb + 8'd1;
            default: m_b2 = alu_opb - 8'd1;
         endcase
      end
      case (aif.ALU_Funct)
         ALU_OR:  begin m_r = alu_opa | m_b2; m_c = m_sc; end
         ALU_AND: m_r = alu_opa & m_b2;
         ALU_XOR: m_r = alu_opa ^ m_b2;
         default: begin
            m_sum = {1'b0, alu_opa} + {1'b0, m_b2} + {8'd0, aif.Cin};
            m_r   = m_sum[7:0];
            m_c   = m_sum[8];
            m_v   = (alu_opa[7] == m_b2[7]) && (m_r[7] != alu_opa[7]);
         end
      endcase
   end
   assign aif.ALU_Rslt = m_r;
   assign aif.NFlg     = m_r[7];
   assign aif.ZFlg     = (m_r == 8'h00);
   assign aif.VFlg     = m_v;
   assign aif.CFlg     = m_c;

   cpu_alu_seq #(.NumB(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_if     (aif),
      .alu_opa    (alu_opa),
      .alu_opb    (alu_opb),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .status_p   (status_p)
`ifdef CPU_ALU_SEQ_PLOAD_EN
      ,
      .p_ld_en    (p_ld_en),
      .p_ld_val   (p_ld_val)
`endif
   );

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_res;
      logic [7:0] exp_p;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] r, input logic [7:0] p);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.exp_res = r; v.exp_p = p;
      vecs.push_back(v);
   endtask

   // One full transaction: wait for ready, accept, then check EXEC, WB and the response cycle.
   task automatic run_vec(input vec_t v, input string tag);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_exec_rv"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_wb_rv"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_wb_ops"}, {16'd0, alu_opa, alu_opb}, 32'd0);
      chk({tag, "_wb_drv"}, {28'd0, 2'(aif.ALU_Funct), aif.ALU_OpB_FunctEn, aif.Cin},
          {28'd0, 2'(ALU_OR), 1'b0, 1'b0});
      @(negedge clk);
      chk({tag, "_rv"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_res"}, 32'(rsp_result), 32'(v.exp_res));
      chk({tag, "_p"}, 32'(status_p), 32'(v.exp_p));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 8'h00; req_b = 8'h00;
`ifdef CPU_ALU_SEQ_PLOAD_EN
      p_ld_en = 1'b0; p_ld_val = 8'h00;
`endif
      //     op           a      b      result p
      add(4'(OP_ADC), 8'h50, 8'h50, 8'hA0, 8'hE4);
      add(4'(OP_ORA), 8'h0F, 8'h30, 8'h3F, 8'h64);
      add(4'(OP_AND), 8'hF0, 8'h0F, 8'h00, 8'h66);
      add(4'(OP_EOR), 8'hFF, 8'h0F, 8'hF0, 8'hE4);
      add(4'(OP_CMP), 8'h10, 8'h10, 8'h00, 8'h67);
      add(4'(OP_BIT), 8'h00, 8'hC0, 8'h00, 8'hE7);
      add(4'(OP_BIT), 8'h0F, 8'h3F, 8'h0F, 8'h25);
      add(4'(OP_SBC), 8'h00, 8'h01, 8'hFF, 8'hA4);
      add(4'(OP_ROL), 8'h55, 8'h80, 8'h00, 8'h27);
      add(4'(OP_ROR), 8'h55, 8'h01, 8'h80, 8'hA5);
      add(4'(OP_INC), 8'hAA, 8'hFF, 8'h00, 8'h27);
      add(4'(OP_DEC), 8'hAA, 8'h00, 8'hFF, 8'hA5);
      add(4'(OP_ASL), 8'h33, 8'h81, 8'h02, 8'h25);
      add(4'(OP_LSR), 8'h33, 8'h02, 8'h01, 8'h24);
      add(4'(OP_ADC), 8'h7F, 8'h01, 8'h80, 8'hE4);
      add(4'(OP_ADC), 8'hFF, 8'h01, 8'h00, 8'h27);
      add(4'd14,      8'h12, 8'h5A, 8'h5A, 8'h27);
      add(4'(OP_ADC), 8'h01, 8'h01, 8'h03, 8'h24);
      add(4'(OP_SBC), 8'h50, 8'h10, 8'h3F, 8'h25);
      add(4'(OP_ROR), 8'h00, 8'h02, 8'h81, 8'hA4);
      add(4'd15,      8'hFF, 8'h00, 8'h00, 8'hA4);
      add(4'(OP_EOR), 8'h3C, 8'h3C, 8'h00, 8'h26);

      // Reset values while rst_n is held low.
      repeat (3) @(negedge clk);
      chk("rst_p", 32'(status_p), 32'h24);
      chk("rst_rv", 32'(rsp_valid), 32'd0);
      chk("rst_res", 32'(rsp_result), 32'd0);
      chk("rst_ops", {16'd0, alu_opa, alu_opb}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      // req_valid held high: accepts exactly every third cycle.
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'(OP_ORA); req_a = 8'h01; req_b = 8'h02;
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("b2b_ready%0d", k), 32'(req_ready), 32'((k % 3) == 0));
         chk($sformatf("b2b_rv%0d", k), 32'(rsp_valid), 32'(((k % 3) == 0) && (k > 0)));
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b_res", 32'(rsp_result), 32'h03);
      chk("b2b_p", 32'(status_p), 32'h24);

      // Reset during EXEC aborts the operation.
      repeat (4) @(negedge clk);
      req_valid = 1'b1; req_op = 4'(OP_ADC); req_a = 8'h7F; req_b = 8'h01;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_rv", 32'(rsp_valid), 32'd0);
      chk("abort_p", 32'(status_p), 32'h24);
      chk("abort_res", 32'(rsp_result), 32'd0);
      chk("abort_ops", {16'd0, alu_opa, alu_opb}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready", 32'(req_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("abort_post_rv%0d", k), 32'(rsp_valid), 32'd0);
         chk($sformatf("abort_post_p%0d", k), 32'(status_p), 32'h24);
         @(negedge clk);
      end

      v.op = 4'(OP_ADC); v.a = 8'h50; v.b = 8'h50; v.exp_res = 8'hA0; v.exp_p = 8'hE4;
      run_vec(v, "post_rst_adc");

`ifdef CPU_ALU_SEQ_PLOAD_EN
      // Preload wins over a simultaneous request in IDLE.
      @(negedge clk);
      p_ld_en = 1'b1; p_ld_val = 8'h03;
      req_valid = 1'b1; req_op = 4'(OP_ORA); req_a = 8'h80; req_b = 8'h00;
      #1 chk("pld_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 begin p_ld_en = 1'b0; req_valid = 1'b0; end
      @(negedge clk);
      chk("pld_p", 32'(status_p), 32'h23);
      chk("pld_idle", 32'(req_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("pld_rv%0d", k), 32'(rsp_valid), 32'd0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
